// File: rtl/seg_disp_pkg.sv
// Shared seven-segment display constants: segment bit order and the hex glyph table.
package seg_disp_pkg;

    localparam int SEG_WIDTH = 7;
    localparam int SEG_A     = 0;
    localparam int SEG_B     = 1;
    localparam int SEG_C     = 2;
    localparam int SEG_D     = 3;
    localparam int SEG_E     = 4;
    localparam int SEG_F     = 5;
    localparam int SEG_G     = 6;

    // Active-high glyphs, bit SEG_G down to bit SEG_A.
    localparam logic [SEG_WIDTH-1:0] SEG_HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder covering the full hex range (active-high).
module seg7_hex_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0]           nibble,
    output logic [SEG_WIDTH-1:0] seg
);

    // Table lookup of the glyph for the nibble.
    always_comb begin
        seg = SEG_HEX_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: per-slot dead time, frame-coherent shadow,
// leading-zero blanking and configurable output polarity, all outputs registered.
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 12500,
    parameter int BLANK_CYCLES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      lz_blank,
    output logic [SEG_WIDTH-1:0]      seg,
    output logic                      seg_dp,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [SEG_WIDTH-1:0]  SEG_OFF_LVL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF_LVL  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_LVL =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
        $error("seg_scan_mux: NUM_DIGITS must be within 1..8");
    end
    if (BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("seg_scan_mux: BLANK_CYCLES must be less than SCAN_DIV");
    end

    logic [CW-1:0]           cnt_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] sh_digits_r;
    logic [NUM_DIGITS-1:0]   sh_dp_r;
    logic                    sh_lz_r;

    logic                    load_s;
    logic                    active_s;
    logic [4*NUM_DIGITS-1:0] view_digits_s;
    logic [NUM_DIGITS-1:0]   view_dp_s;
    logic                    view_lz_s;
    logic                    zero_run_s;
    logic [NUM_DIGITS-1:0]   blank_vec_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [3:0]              cur_nibble_s;
    logic [SEG_WIDTH-1:0]    dec_seg_s;
    logic [SEG_WIDTH-1:0]    seg_next_s;
    logic                    dp_next_s;
    logic [NUM_DIGITS-1:0]   sel_next_s;
    logic                    frame_next_s;

    assign load_s = (cnt_r == {CW{1'b0}}) && (idx_r == {IW{1'b0}});

    if (BLANK_CYCLES == 0) begin : g_no_dead_time
        assign active_s = 1'b1;
    end else begin : g_dead_time
        localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
        assign active_s = (cnt_r >= CNT_BLANK);
    end

    // Slot counter and digit index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= {IW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : (idx_r + {{(IW-1){1'b0}}, 1'b1});
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Shadow capture at the start of every frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_digits_r <= {(4*NUM_DIGITS){1'b0}};
            sh_dp_r     <= {NUM_DIGITS{1'b0}};
            sh_lz_r     <= 1'b0;
        end else if (load_s) begin
            sh_digits_r <= digits;
            sh_dp_r     <= dp;
            sh_lz_r     <= lz_blank;
        end else begin
            sh_digits_r <= sh_digits_r;
            sh_dp_r     <= sh_dp_r;
            sh_lz_r     <= sh_lz_r;
        end
    end

    // On the load cycle the value being captured is already this frame's shadow.
    always_comb begin
        view_digits_s = sh_digits_r;
        view_dp_s     = sh_dp_r;
        view_lz_s     = sh_lz_r;
        if (load_s) begin
            view_digits_s = digits;
            view_dp_s     = dp;
            view_lz_s     = lz_blank;
        end else begin
            view_digits_s = sh_digits_r;
            view_dp_s     = sh_dp_r;
            view_lz_s     = sh_lz_r;
        end
    end

    // Leading-zero mask: digit i blanks when it and every higher nibble are zero.
    always_comb begin
        zero_run_s  = 1'b1;
        blank_vec_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s     = zero_run_s & (view_digits_s[4*i +: 4] == 4'h0);
            blank_vec_s[i] = view_lz_s & zero_run_s & (i != 0);
        end
    end

    // One-hot digit select from the index.
    always_comb begin
        onehot_s = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (idx_r == IW'(i));
        end
    end

    assign cur_nibble_s = view_digits_s[{idx_r, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble (cur_nibble_s),
        .seg    (dec_seg_s)
    );

    // Active-high output values for the current (cnt, idx) state.
    always_comb begin
        seg_next_s   = 7'h00;
        dp_next_s    = 1'b0;
        sel_next_s   = {NUM_DIGITS{1'b0}};
        frame_next_s = (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
        if (active_s) begin
            sel_next_s = onehot_s;
            if (!blank_vec_s[idx_r]) begin
                seg_next_s = dec_seg_s;
                dp_next_s  = view_dp_s[idx_r];
            end else begin
                seg_next_s = 7'h00;
                dp_next_s  = 1'b0;
            end
        end else begin
            sel_next_s = {NUM_DIGITS{1'b0}};
            seg_next_s = 7'h00;
            dp_next_s  = 1'b0;
        end
    end

    // Registered outputs with polarity applied.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF_LVL;
            seg_dp     <= DP_OFF_LVL;
            dig_sel    <= DIG_OFF_LVL;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next_s ^ SEG_OFF_LVL;
            seg_dp     <= dp_next_s ^ DP_OFF_LVL;
            dig_sel    <= sel_next_s ^ DIG_OFF_LVL;
            frame_done <= frame_next_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: cycle-count reference model plus directed literal checks.
module tb_seg_scan_mux;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz_blank;

    logic [6:0] seg0, seg1, seg2;
    logic       seg_dp0, seg_dp1, seg_dp2;
    logic [3:0] dig_sel0, dig_sel1;
    logic [0:0] dig_sel2;
    logic       fd0, fd1, fd2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
                   .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut0 (
        .clock(clock), .reset(reset), .digits(digits), .dp(dp), .lz_blank(lz_blank),
        .seg(seg0), .seg_dp(seg_dp0), .dig_sel(dig_sel0), .frame_done(fd0));

    seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
                   .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut1 (
        .clock(clock), .reset(reset), .digits(digits), .dp(dp), .lz_blank(lz_blank),
        .seg(seg1), .seg_dp(seg_dp1), .dig_sel(dig_sel1), .frame_done(fd1));

    seg_scan_mux #(.NUM_DIGITS(1), .SCAN_DIV(3), .BLANK_CYCLES(0),
                   .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut2 (
        .clock(clock), .reset(reset), .digits(digits[3:0]), .dp(dp[0:0]), .lz_blank(lz_blank),
        .seg(seg2), .seg_dp(seg_dp2), .dig_sel(dig_sel2), .frame_done(fd2));

    localparam int P_N   [3] = '{4, 4, 1};
    localparam int P_SD  [3] = '{8, 8, 3};
    localparam int P_BL  [3] = '{2, 2, 0};
    localparam bit P_SAL [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit P_DAL [3] = '{1'b1, 1'b1, 1'b0};
    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: edges seen since reset release and the frame shadow, per instance.
    int          kc    [3];
    logic [31:0] shd   [3];
    logic [7:0]  shp   [3];
    logic        shl   [3];
    logic [16:0] e_out [3];  // {frame_done, seg_dp, seg, dig_sel zero-extended to 8}
    bit          model_valid = 1'b0;

    function automatic logic [7:0] dig_mask(input int n);
        logic [7:0] full;
        full = 8'hFF;
        return full >> (8 - n);
    endfunction

    function automatic logic [31:0] in_dig(input int n);
        logic [31:0] one;
        one = 32'h1;
        return 32'(digits) & ((one << (4 * n)) - 32'h1);
    endfunction

    function automatic logic [16:0] reset_val(input int d);
        logic [6:0] s;
        logic [7:0] sel;
        s   = P_SAL[d] ? 7'h7F : 7'h00;
        sel = P_DAL[d] ? dig_mask(P_N[d]) : 8'h00;
        return {1'b0, P_SAL[d], s, sel};
    endfunction

    // Expected outputs after the edge that ends cycle k of the scan.
    function automatic logic [16:0] model_eval(input int d, input int k, input logic [31:0] sdig,
                                               input logic [7:0] sdp, input logic slz);
        int n, sd, cnt, idx;
        bit fd, act, blank;
        logic [6:0] s;
        logic       p;
        logic [7:0] sel;
        logic [7:0] one;
        n   = P_N[d];
        sd  = P_SD[d];
        cnt = k % sd;
        idx = (k / sd) % n;
        fd  = ((k % (sd * n)) == (sd * n - 1));
        act = (cnt >= P_BL[d]);
        blank = 1'b0;
        if (slz && idx > 0) begin
            blank = 1'b1;
            for (int j = idx; j < n; j++) if (sdig[4*j +: 4] != 4'h0) blank = 1'b0;
        end
        s   = (act && !blank) ? HEX[sdig[4*idx +: 4]] : 7'h00;
        p   = (act && !blank) ? sdp[idx] : 1'b0;
        one = 8'h01;
        sel = act ? (one << idx) : 8'h00;
        if (P_SAL[d]) begin s = ~s; p = ~p; end
        if (P_DAL[d]) sel = ~sel & dig_mask(n);
        return {fd, p, s, sel};
    endfunction

    function automatic bit is_load(input int d);
        return (kc[d] % (P_SD[d] * P_N[d])) == 0;
    endfunction

    // Reference model advance on every clock edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                kc[d]    <= 0;
                shd[d]   <= 32'h0;
                shp[d]   <= 8'h0;
                shl[d]   <= 1'b0;
                e_out[d] <= reset_val(d);
            end
            model_valid <= 1'b1;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (is_load(d)) begin
                    shd[d]   <= in_dig(P_N[d]);
                    shp[d]   <= 8'(dp) & dig_mask(P_N[d]);
                    shl[d]   <= lz_blank;
                    e_out[d] <= model_eval(d, kc[d], in_dig(P_N[d]), 8'(dp) & dig_mask(P_N[d]), lz_blank);
                end else begin
                    e_out[d] <= model_eval(d, kc[d], shd[d], shp[d], shl[d]);
                end
                kc[d] <= kc[d] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison of all instances against the model.
    always @(negedge clock) begin
        if (model_valid) begin
            check("model.dut0", {fd0, seg_dp0, seg0, 4'b0000, dig_sel0}, e_out[0]);
            check("model.dut1", {fd1, seg_dp1, seg1, 4'b0000, dig_sel1}, e_out[1]);
            check("model.dut2", {fd2, seg_dp2, seg2, 7'b0000000, dig_sel2}, e_out[2]);
        end
    end

    // One full frame of dut0/dut1 with literal glyph expectations per digit.
    task automatic frame_check(input string tag, input logic [27:0] segs, input logic [3:0] dps,
                               input bit chg, input logic [15:0] new_digits);
        int idx;
        logic [3:0] one;
        logic [3:0] exp_sel;
        one = 4'b0001;
        for (int p = 0; p < 32; p++) begin
            @(negedge clock);
            if (chg && p == 12) digits = new_digits;
            if (p % 8 == 0)
                check({tag, ".dead"}, 17'({seg_dp0, seg0, dig_sel0}), 17'({1'b0, 7'h00, 4'hF}));
            if (p % 8 == 2) begin
                idx     = p / 8;
                exp_sel = 4'hF ^ (one << idx);
                check({tag, ".dig"}, 17'({seg_dp0, seg0, dig_sel0}),
                      17'({dps[idx], segs[7*idx +: 7], exp_sel}));
                check({tag, ".inv"}, 17'({seg_dp1, seg1, dig_sel1}),
                      17'({~dps[idx], ~segs[7*idx +: 7], exp_sel}));
            end
            if (p == 31) check({tag, ".frame"}, 17'(fd0), 17'(1'b1));
        end
    endtask

    task automatic reset_literals(input string tag);
        check({tag, ".d0"}, 17'({fd0, seg_dp0, seg0, dig_sel0}), 17'({1'b0, 1'b0, 7'h00, 4'hF}));
        check({tag, ".d1"}, 17'({fd1, seg_dp1, seg1, dig_sel1}), 17'({1'b0, 1'b1, 7'h7F, 4'hF}));
        check({tag, ".d2"}, 17'({fd2, seg_dp2, seg2, dig_sel2}), 17'({1'b0, 1'b0, 7'h00, 1'b0}));
    endtask

    initial begin
        logic [15:0] full;
        logic [15:0] r;
        int nz, chg_at;
        full     = 16'hFFFF;
        reset    = 1'b0;
        digits   = 16'h0000;
        dp       = 4'b0000;
        lz_blank = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset_literals("reset");

        // Basic scan, two frames to see frame_done repeat.
        digits = 16'h4321;
        reset  = 1'b0;
        frame_check("basic", {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000, 1'b0, 16'h0000);
        frame_check("basic2", {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000, 1'b0, 16'h0000);

        // Leading-zero blanking.
        digits   = 16'h0050;
        lz_blank = 1'b1;
        frame_check("lz", {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000, 1'b0, 16'h0000);

        // Mid-frame input change only takes effect at the next frame.
        digits   = 16'h1111;
        lz_blank = 1'b0;
        frame_check("tear", {7'h06, 7'h06, 7'h06, 7'h06}, 4'b0000, 1'b1, 16'h2222);
        frame_check("tear2", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, 1'b0, 16'h0000);

        // Full hex range with decimal point, both segment polarities.
        digits = 16'hFEDC;
        dp     = 4'b0001;
        frame_check("hex", {7'h71, 7'h79, 7'h5E, 7'h39}, 4'b0001, 1'b0, 16'h0000);

        // Mid-frame reset while idx=2, cnt=5.
        for (int p = 0; p < 21; p++) @(negedge clock);
        digits = 16'h8765;
        dp     = 4'b0000;
        #1 reset = 1'b1;
        #1 reset_literals("midreset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        frame_check("restart", {7'h7F, 7'h07, 7'h7D, 7'h6D}, 4'b0000, 1'b0, 16'h0000);

        // Randomized frames with leading zeros and mid-frame changes.
        for (int f = 0; f < 12; f++) begin
            nz       = $urandom_range(0, 4);
            r        = 16'($urandom);
            digits   = r & (full >> (4 * nz));
            dp       = 4'($urandom);
            lz_blank = 1'($urandom_range(0, 1));
            chg_at   = $urandom_range(0, 31);
            for (int p = 0; p < 32; p++) begin
                @(negedge clock);
                if (p == chg_at) begin
                    digits   = 16'($urandom);
                    dp       = 4'($urandom);
                    lz_blank = 1'($urandom_range(0, 1));
                end
            end
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
